vmerge_seq: RTL and testbench

VMERGE_SEQ -- requirements
Module: vmerge_seq

---
 rtl/vmerge_seq.sv | 182 ++++++++++++++++++
 tb/tb_vmerge_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmerge_seq.sv
// Vector merge sequencer: splits a command into 8-byte beats, builds the per-byte select and
// enable masks, and pairs returning merge results with queued writeback side information.
module vmerge_seq #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned VL_WIDTH      = 11,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned MERGE_LATENCY = 6,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [1:0]            cmd_sew,
  input  logic [ADDR_WIDTH-1:0] cmd_vd,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_vec0,
  input  logic [DATA_WIDTH-1:0] op_vec1,
  input  logic [7:0]            op_mask,
  output logic                  merge_in_valid,
  output logic [7:0]            merge_in_mask,
  output logic [DATA_WIDTH-1:0] merge_in_vec0,
  output logic [DATA_WIDTH-1:0] merge_in_vec1,
  input  logic                  merge_out_valid,
  input  logic [DATA_WIDTH-1:0] merge_out_vec,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [7:0]            wb_be,
  output logic                  wb_last,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ELEM_W = VL_WIDTH + 1;
  localparam int unsigned BYTE_W = VL_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            be;
    logic                  last;
  } side_t;

  state_t                state;
  logic [VL_WIDTH-1:0]   vl_q;
  logic [VL_WIDTH-1:0]   beats_q;
  logic [VL_WIDTH-1:0]   beat_q;
  logic [1:0]            sew_q;
  logic [ADDR_WIDTH-1:0] vd_q;
  logic [ELEM_W-1:0]     elem_q;

  side_t                 fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  last_beat;
  logic [7:0]            be_c;
  logic [7:0]            sel_c;
  logic [BYTE_W-1:0]     cmd_bytes;
  side_t                 push_entry;
  side_t                 head;

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign fifo_full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty     = (fifo_cnt == '0);
  assign op_ready       = (state == RUN) && (beat_q < beats_q) && !fifo_full;
  assign push           = op_valid && op_ready;
  assign pop            = merge_out_valid && !fifo_empty;
  assign last_beat      = (beat_q == beats_q - VL_WIDTH'(1));
  assign head           = fifo_mem[rd_ptr];
  assign cmd_bytes      = BYTE_W'(cmd_vl) << cmd_sew;

  assign merge_in_valid = push;
  assign merge_in_mask  = sel_c;
  assign merge_in_vec0  = op_vec0;
  assign merge_in_vec1  = op_vec1;
  assign push_entry     = '{addr: vd_q + ADDR_WIDTH'(beat_q), be: be_c, last: last_beat};

  // Byte j belongs to element j>>sew of the current beat; bytes past vl are disabled.
  always_comb begin
    be_c  = '0;
    sel_c = '0;
    for (int j = 0; j < 8; j++) begin
      be_c[j]  = (elem_q + ELEM_W'(j >> sew_q)) < ELEM_W'(vl_q);
      sel_c[j] = op_mask[3'(j >> sew_q)] && be_c[j];
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      vl_q     <= '0;
      beats_q  <= '0;
      beat_q   <= '0;
      sew_q    <= '0;
      vd_q     <= '0;
      elem_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_addr  <= '0;
      wb_be    <= '0;
      wb_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_addr  <= '0;
      wb_be    <= '0;
      wb_last  <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            vl_q    <= cmd_vl;
            sew_q   <= cmd_sew;
            vd_q    <= cmd_vd;
            beats_q <= VL_WIDTH'((cmd_bytes + BYTE_W'(7)) >> 3);
            beat_q  <= '0;
            elem_q  <= '0;
            if (cmd_vl == '0) done  <= 1'b1;
            else              state <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            beat_q <= beat_q + VL_WIDTH'(1);
            elem_q <= elem_q + ELEM_W'(8 >> sew_q);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Results return in issue order, so the FIFO head always describes the current result.
      if (pop) begin
        wb_valid <= 1'b1;
        wb_data  <= merge_out_vec;
        wb_addr  <= head.addr;
        wb_be    <= head.be;
        wb_last  <= head.last;
        done     <= head.last;
        rd_ptr   <= ptr_inc(rd_ptr);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= ptr_inc(wr_ptr);
      end

      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // Side FIFO must cover every beat in flight through the merge datapath.
  assert property (@(posedge clk) disable iff (!rst) FIFO_DEPTH >= MERGE_LATENCY);

endmodule

// File: tb/tb_vmerge_seq.sv
// Directed testbench for vmerge_seq with a fixed-latency byte-select merge datapath model.
module tb_vmerge_seq;

  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_vl;
  logic [1:0]  cmd_sew;
  logic [7:0]  cmd_vd;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_vec0;
  logic [63:0] op_vec1;
  logic [7:0]  op_mask;
  logic        merge_in_valid;
  logic [7:0]  merge_in_mask;
  logic [63:0] merge_in_vec0;
  logic [63:0] merge_in_vec1;
  logic        merge_out_valid;
  logic [63:0] merge_out_vec;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [7:0]  wb_addr;
  logic [7:0]  wb_be;
  logic        wb_last;
  logic        done;
  logic        busy;

  vmerge_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
    .cmd_vd(cmd_vd),
    .op_valid(op_valid), .op_ready(op_ready), .op_vec0(op_vec0), .op_vec1(op_vec1),
    .op_mask(op_mask),
    .merge_in_valid(merge_in_valid), .merge_in_mask(merge_in_mask),
    .merge_in_vec0(merge_in_vec0), .merge_in_vec1(merge_in_vec1),
    .merge_out_valid(merge_out_valid), .merge_out_vec(merge_out_vec),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr), .wb_be(wb_be),
    .wb_last(wb_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Merge datapath model: byte select by mask, fixed latency, no reset.
  logic [LAT-1:0] vpipe = '0;
  logic [63:0]    dpipe [LAT];

  function automatic logic [63:0] merge_bytes(input logic [7:0] m, input logic [63:0] a,
                                               input logic [63:0] b);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = m[j] ? b[j*8 +: 8] : a[j*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    vpipe    <= {vpipe[LAT-2:0], merge_in_valid};
    dpipe[0] <= merge_bytes(merge_in_mask, merge_in_vec0, merge_in_vec1);
    for (int i = 1; i < int'(LAT); i++) dpipe[i] <= dpipe[i-1];
  end

  assign merge_out_valid = vpipe[LAT-1];
  assign merge_out_vec   = dpipe[LAT-1];

  typedef struct {
    logic [63:0] data;
    logic [7:0]  addr;
    logic [7:0]  be;
    logic        last;
    logic        done;
    int          cyc;
  } wb_t;

  int   cyc = 0;
  int   iss_q [$];
  wb_t  wb_q [$];
  wb_t  mon_e;
  int   n_done = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (merge_in_valid) iss_q.push_back(cyc);
    if (wb_valid) begin
      mon_e.data = wb_data;
      mon_e.addr = wb_addr;
      mon_e.be   = wb_be;
      mon_e.last = wb_last;
      mon_e.done = done;
      mon_e.cyc  = cyc;
      wb_q.push_back(mon_e);
    end
    if (done) n_done = n_done + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    iss_q.delete();
    wb_q.delete();
    n_done = 0;
  endtask

  task automatic send_cmd(input int vl, input int sew, input int vd);
    cmd_valid = 1'b1;
    cmd_vl    = 11'(vl);
    cmd_sew   = 2'(sew);
    cmd_vd    = 8'(vd);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wb(input int n);
    int t = 0;
    while (wb_q.size() < n && t < 100) begin
      step();
      t++;
    end
    check("wb_count", 64'(wb_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_vl    = '0;
    cmd_sew   = '0;
    cmd_vd    = '0;
    op_valid  = 1'b0;
    op_vec0   = '0;
    op_vec1   = '0;
    op_mask   = '0;
    repeat (2) step();

    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_op_ready", 64'(op_ready), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b1;
    step();

    // sew=8b, vl=8, single beat, mask 0xA5
    clear_mon();
    send_cmd(8, 0, 'h10);
    check("t1_busy", 64'(busy), 64'd1);
    op_valid = 1'b1;
    op_mask  = 8'hA5;
    op_vec0  = 64'h1111_1111_1111_1111;
    op_vec1  = 64'h2222_2222_2222_2222;
    #1;
    check("t1_in_valid", 64'(merge_in_valid), 64'd1);
    check("t1_in_mask", 64'(merge_in_mask), 64'hA5);
    step();
    op_valid = 1'b0;
    wait_wb(1);
    step();
    if (wb_q.size() >= 1 && iss_q.size() >= 1) begin
      check("t1_latency", 64'(wb_q[0].cyc - iss_q[0]), 64'd7);
      check("t1_data", wb_q[0].data, 64'h2211_2211_1122_1122);
      check("t1_addr", 64'(wb_q[0].addr), 64'h10);
      check("t1_be", 64'(wb_q[0].be), 64'hFF);
      check("t1_last", 64'(wb_q[0].last), 64'd1);
      check("t1_done", 64'(wb_q[0].done), 64'd1);
    end
    check("t1_idle", 64'(cmd_ready), 64'd1);

    // sew=32b, vl=3: two beats, second partially enabled
    clear_mon();
    send_cmd(3, 2, 'h20);
    op_valid = 1'b1;
    op_vec0  = 64'h0;
    op_vec1  = 64'hFFFF_FFFF_FFFF_FFFF;
    op_mask  = 8'b10;
    #1;
    check("t2_b0_mask", 64'(merge_in_mask), 64'hF0);
    step();
    op_mask = 8'b01;
    #1;
    check("t2_b1_ready", 64'(op_ready), 64'd1);
    check("t2_b1_mask", 64'(merge_in_mask), 64'h0F);
    step();
    op_valid = 1'b0;
    #1;
    check("t2_no_third", 64'(op_ready), 64'd0);
    wait_wb(2);
    step();
    if (wb_q.size() >= 2) begin
      check("t2_b0_data", wb_q[0].data, 64'hFFFF_FFFF_0000_0000);
      check("t2_b0_be", 64'(wb_q[0].be), 64'hFF);
      check("t2_b0_last", 64'(wb_q[0].last), 64'd0);
      check("t2_b0_done", 64'(wb_q[0].done), 64'd0);
      check("t2_b1_data", wb_q[1].data, 64'h0000_0000_FFFF_FFFF);
      check("t2_b1_addr", 64'(wb_q[1].addr), 64'h21);
      check("t2_b1_be", 64'(wb_q[1].be), 64'h0F);
      check("t2_b1_last", 64'(wb_q[1].last), 64'd1);
    end
    check("t2_done_cnt", 64'(n_done), 64'd1);

    // vl=0: immediate done, no beats
    clear_mon();
    op_valid = 1'b1;
    send_cmd(0, 1, 'h30);
    check("t3_done", 64'(done), 64'd1);
    check("t3_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t3_op_ready", 64'(op_ready), 64'd0);
    step();
    check("t3_done_clear", 64'(done), 64'd0);
    op_valid = 1'b0;
    repeat (10) step();
    check("t3_no_issue", 64'(iss_q.size()), 64'd0);
    check("t3_no_wb", 64'(wb_q.size()), 64'd0);
    check("t3_done_cnt", 64'(n_done), 64'd1);

    // sew=8b, vl=128, op_valid held: 16 back-to-back beats, address wraps past 0xFF
    clear_mon();
    send_cmd(128, 0, 'hF8);
    op_valid = 1'b1;
    op_mask  = 8'h0F;
    op_vec0  = 64'h0;
    op_vec1  = 64'hAAAA_BBBB_CCCC_DDDD;
    repeat (20) step();
    op_valid = 1'b0;
    wait_wb(16);
    repeat (10) step();
    check("t4_issues", 64'(iss_q.size()), 64'd16);
    if (iss_q.size() == 16) check("t4_contig", 64'(iss_q[15] - iss_q[0]), 64'd15);
    check("t4_wb_total", 64'(wb_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < wb_q.size(); i++) begin
      check($sformatf("t4_addr%0d", i), 64'(wb_q[i].addr), 64'(8'(8'hF8 + i)));
      check($sformatf("t4_last%0d", i), 64'(wb_q[i].last), 64'(i == 15));
      check($sformatf("t4_data%0d", i), wb_q[i].data, 64'h0000_0000_CCCC_DDDD);
    end
    check("t4_done_cnt", 64'(n_done), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);

    // sew=64b, vl=2, op_valid alternating
    clear_mon();
    send_cmd(2, 3, 'h40);
    op_valid = 1'b1;
    op_mask  = 8'h01;
    op_vec0  = 64'h0123_4567_89AB_CDEF;
    op_vec1  = 64'hFEDC_BA98_7654_3210;
    #1;
    check("t5_b0_mask", 64'(merge_in_mask), 64'hFF);
    step();
    op_valid = 1'b0;
    #1;
    check("t5_gap", 64'(merge_in_valid), 64'd0);
    step();
    op_valid = 1'b1;
    op_mask  = 8'h00;
    op_vec0  = 64'h5555_5555_5555_5555;
    op_vec1  = 64'h6666_6666_6666_6666;
    #1;
    check("t5_b1_mask", 64'(merge_in_mask), 64'h00);
    step();
    op_valid = 1'b0;
    wait_wb(2);
    step();
    if (iss_q.size() == 2) check("t5_spacing", 64'(iss_q[1] - iss_q[0]), 64'd2);
    if (wb_q.size() >= 2) begin
      check("t5_b0_data", wb_q[0].data, 64'hFEDC_BA98_7654_3210);
      check("t5_b0_addr", 64'(wb_q[0].addr), 64'h40);
      check("t5_b0_be", 64'(wb_q[0].be), 64'hFF);
      check("t5_b1_data", wb_q[1].data, 64'h5555_5555_5555_5555);
      check("t5_b1_addr", 64'(wb_q[1].addr), 64'h41);
      check("t5_b1_be", 64'(wb_q[1].be), 64'hFF);
      check("t5_b1_last", 64'(wb_q[1].last), 64'd1);
    end

    // Reset after 3 of 16 beats: in-flight results must be dropped
    clear_mon();
    send_cmd(128, 0, 'h00);
    op_valid = 1'b1;
    op_mask  = 8'hFF;
    op_vec1  = 64'h7777_7777_7777_7777;
    repeat (3) step();
    check("t6_issued", 64'(iss_q.size()), 64'd3);
    rst = 1'b0;
    #1;
    check("t6_wb_valid", 64'(wb_valid), 64'd0);
    check("t6_wb_data", wb_data, 64'd0);
    check("t6_wb_addr", 64'(wb_addr), 64'd0);
    check("t6_wb_be", 64'(wb_be), 64'd0);
    check("t6_wb_last", 64'(wb_last), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_op_ready", 64'(op_ready), 64'd0);
    check("t6_in_valid", 64'(merge_in_valid), 64'd0);
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    op_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (12) step();
    check("t6_no_wb", 64'(wb_q.size()), 64'd0);
    check("t6_no_done", 64'(n_done), 64'd0);
    check("t6_idle", 64'(cmd_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
